// File: rtl/reg_bank32_pkg.sv
// Shared constants and FSM encoding for the 32x32 register bank and the read mux
// that sits downstream of it.
package regbank_pkg;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;
endpackage

// File: rtl/reg_bank32_if.sv
// Write/clear handshake and flattened contents of the register bank.
interface reg_bank32_if;
    logic                                                   WrEn;
    logic [regbank_pkg::ADDR_W-1:0]                         WrAddr;
    logic [regbank_pkg::DATA_W-1:0]                         WrData;
    logic                                                   ClrReq;
    logic                                                   Busy;
    logic                                                   ClrDone;
    logic [regbank_pkg::NUM_REGS*regbank_pkg::DATA_W-1:0]   RegsOut;
    logic [regbank_pkg::NUM_REGS-1:0]                       DirtyMask;

    modport master (
        output WrEn, WrAddr, WrData, ClrReq,
        input  Busy, ClrDone, RegsOut, DirtyMask
    );

    modport slave (
        input  WrEn, WrAddr, WrData, ClrReq,
        output Busy, ClrDone, RegsOut, DirtyMask
    );
endinterface

// File: rtl/reg_bank32_decoder5to32.sv
// One-hot register select decoder; all outputs low when i_en is low.
module decoder5to32
    import regbank_pkg::*;
(
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [NUM_REGS-1:0] o_sel
);

    always_comb begin
        o_sel = '0;
        if (i_en) begin
            o_sel[i_addr] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank32.sv
// 32x32 register bank with per-register dirty mask and a one-register-per-cycle
// bulk clear sequence; storage flops drive the downstream mux directly.
module reg_bank32
    import regbank_pkg::*;
#(
    parameter int ZERO_REG = 1
) (
    input  logic         Clk,
    input  logic         Reset,
    reg_bank32_if.slave  bus
);

    localparam logic [NUM_REGS-1:0] ZERO_MASK =
        (ZERO_REG != 0) ? {{(NUM_REGS-1){1'b0}}, 1'b1} : '0;

    state_t                           r_state;
    state_t                           w_state_nxt;
    logic [ADDR_W-1:0]                r_idx;
    logic [ADDR_W-1:0]                w_idx_nxt;
    logic                             r_clr_done;
    logic                             w_done_nxt;
    logic                             w_busy;
    logic [NUM_REGS-1:0]              w_wr_dec;
    logic [NUM_REGS-1:0]              w_wr_sel;
    logic [NUM_REGS-1:0]              w_clr_sel;
    logic [NUM_REGS-1:0][DATA_W-1:0]  r_regs;
    logic [NUM_REGS-1:0]              r_dirty;

    assign w_busy = (r_state == ST_CLEAR);

    decoder5to32 u_wr_dec (
        .i_en   (bus.WrEn & ~w_busy),
        .i_addr (bus.WrAddr),
        .o_sel  (w_wr_dec)
    );

    decoder5to32 u_clr_dec (
        .i_en   (w_busy),
        .i_addr (r_idx),
        .o_sel  (w_clr_sel)
    );

    // Register 0 is read-only zero when ZERO_REG is set, so its strobe is masked off.
    assign w_wr_sel = w_wr_dec & ~ZERO_MASK;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_clr_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_clr_done <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.ClrReq) begin
                    w_state_nxt = ST_CLEAR;
                    w_idx_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                // Terminal compare rather than wrap keeps the pass at exactly NUM_REGS edges.
                if (r_idx == ADDR_W'(NUM_REGS - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + ADDR_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_regs  <= '0;
            r_dirty <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_clr_sel[i]) begin
                    r_regs[i]  <= '0;
                    r_dirty[i] <= 1'b0;
                end else if (w_wr_sel[i]) begin
                    r_regs[i]  <= bus.WrData;
                    r_dirty[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.Busy      = w_busy;
    assign bus.ClrDone   = r_clr_done;
    assign bus.RegsOut   = r_regs;
    assign bus.DirtyMask = r_dirty;

endmodule
